// File: rtl/ser_pkg.sv
// Shared types for the FIFO read-side serializer.
package ser_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_e;

endpackage

// File: rtl/fifo_rd_serializer.sv
// Pops IN_W-bit words from a show-ahead FIFO and emits them as RATIO OUT_W-bit beats.
// Define SER_MSB_FIRST_EN to emit the most significant slice first (default: LSB first).
//
// state | meaning
// IDLE  | no word held, pop as soon as the FIFO is non-empty
// SHIFT | word held in hold register, beats pending on o_data
module fifo_rd_serializer
   import ser_pkg::*;
#(
   parameter int IN_W  = 128,
   parameter int OUT_W = 32
) (
   input  logic             clk,
   input  logic             rstn,
   output logic             o_fifo_rden,
   input  logic [IN_W-1:0]  i_fifo_rddata,
   input  logic             i_fifo_empty,
   output logic             o_valid,
   output logic [OUT_W-1:0] o_data,
   output logic             o_last,
   input  logic             i_ready
);

   localparam int RATIO = IN_W / OUT_W;
   localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

   if ((IN_W % OUT_W) != 0 || RATIO < 2) begin : g_bad_ratio
      $error("fifo_rd_serializer: IN_W must be a multiple of OUT_W with ratio >= 2");
   end

   ser_state_e       state;
   logic [IN_W-1:0]  hold;
   logic [IDX_W-1:0] beat_idx;
   logic             xfer;
   logic             last_xfer;
   logic             pop;
   int               slice_sel;

   assign o_valid   = (state == SHIFT);
   assign o_last    = o_valid && (beat_idx == LAST_IDX);
   assign xfer      = o_valid && i_ready;
   assign last_xfer = xfer && o_last;

   // Refill on the last beat's transfer so consecutive words stream without a bubble.
   assign pop         = rstn && !i_fifo_empty && ((state == IDLE) || last_xfer);
   assign o_fifo_rden = pop;

   always_comb begin
      slice_sel = 0;
`ifdef SER_MSB_FIRST_EN
      slice_sel = int'(LAST_IDX - beat_idx);
`else
      slice_sel = int'(beat_idx);
`endif
   end

   assign o_data = OUT_W'(hold >> (slice_sel * OUT_W));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         hold     <= '0;
         beat_idx <= '0;
      end else begin
         if (pop) begin
            hold     <= i_fifo_rddata;
            beat_idx <= '0;
            state    <= SHIFT;
         end else if (last_xfer) begin
            state    <= IDLE;
         end else if (xfer) begin
            beat_idx <= beat_idx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// Self-checking bench for fifo_rd_serializer: queue-based beat model plus directed literal checks.
module tb_fifo_rd_serializer;

   localparam int IN_W  = 128;
   localparam int OUT_W = 32;
   localparam int RATIO = IN_W / OUT_W;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             o_fifo_rden;
   logic [IN_W-1:0]  i_fifo_rddata = '0;
   logic             i_fifo_empty = 1'b1;
   logic             o_valid;
   logic [OUT_W-1:0] o_data;
   logic             o_last;
   logic             i_ready = 1'b0;

   always #5 clk = ~clk;

   fifo_rd_serializer #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .o_fifo_rden  (o_fifo_rden),
      .i_fifo_rddata(i_fifo_rddata),
      .i_fifo_empty (i_fifo_empty),
      .o_valid      (o_valid),
      .o_data       (o_data),
      .o_last       (o_last),
      .i_ready      (i_ready)
   );

   logic [IN_W-1:0]  fifo_q[$];
   logic [OUT_W-1:0] beat_q[$];
   int               n_cmp = 0;
   int               n_bad = 0;
   bit               pop_pend = 1'b0;
   logic             s_valid, s_last, s_rden;
   logic [OUT_W-1:0] s_data;

   logic [IN_W-1:0]  word_a = 128'h44444444_33333333_22222222_11111111;
   logic [IN_W-1:0]  word_b = 128'h88888888_77777777_66666666_55555555;
   logic [OUT_W-1:0] lit_a[4];
   logic [OUT_W-1:0] lit_b0;

   function automatic logic [OUT_W-1:0] slice_of(input logic [IN_W-1:0] w, input int k);
      logic [IN_W-1:0] t;
      t = w >> (k * OUT_W);
      return t[OUT_W-1:0];
   endfunction

   task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, compare DUT against the beat-queue model, advance the model.
   task automatic step(input logic rdy, input logic rst_lvl);
      logic             e_valid, e_last, e_rden;
      logic [OUT_W-1:0] e_data;
      @(negedge clk);
      if (pop_pend && fifo_q.size() > 0) fifo_q.delete(0);
      pop_pend      = 1'b0;
      rstn          = rst_lvl;
      i_ready       = rdy;
      i_fifo_empty  = (fifo_q.size() == 0);
      i_fifo_rddata = (fifo_q.size() > 0) ? fifo_q[0] : '0;
      #1;
      if (!rst_lvl) beat_q.delete();
      e_valid = (beat_q.size() > 0);
      e_data  = e_valid ? beat_q[0] : '0;
      e_last  = (beat_q.size() == 1);
      e_rden  = rst_lvl && (fifo_q.size() > 0) &&
                ((beat_q.size() == 0) || (beat_q.size() == 1 && rdy));
      s_valid = o_valid;
      s_data  = o_data;
      s_last  = o_last;
      s_rden  = o_fifo_rden;
      chk("model_valid", {31'b0, s_valid}, {31'b0, e_valid});
      chk("model_last",  {31'b0, s_last},  {31'b0, e_last});
      chk("model_rden",  {31'b0, s_rden},  {31'b0, e_rden});
      if (e_valid || !rst_lvl) chk("model_data", s_data, e_data);
      if (e_valid && rdy) void'(beat_q.pop_front());
      if (e_rden) begin
         for (int j = 0; j < RATIO; j++) begin
`ifdef SER_MSB_FIRST_EN
            beat_q.push_back(slice_of(fifo_q[0], RATIO - 1 - j));
`else
            beat_q.push_back(slice_of(fifo_q[0], j));
`endif
         end
      end
      pop_pend = s_rden;
   endtask

   task automatic drain();
      repeat (8) step(1'b1, 1'b1);
   endtask

   initial begin
      int pops, beats, runs, seen;
      bit prev_v, rden_at_last, first_last_seen;

`ifdef SER_MSB_FIRST_EN
      lit_a[0] = 32'h44444444; lit_a[1] = 32'h33333333;
      lit_a[2] = 32'h22222222; lit_a[3] = 32'h11111111;
      lit_b0   = 32'h88888888;
`else
      lit_a[0] = 32'h11111111; lit_a[1] = 32'h22222222;
      lit_a[2] = 32'h33333333; lit_a[3] = 32'h44444444;
      lit_b0   = 32'h55555555;
`endif

      // Reset state
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      chk("rst_valid", {31'b0, s_valid}, 32'd0);
      chk("rst_data", s_data, 32'd0);
      chk("rst_rden", {31'b0, s_rden}, 32'd0);

      // Single word
      fifo_q.push_back(word_a);
      for (int c = 0; c < 6; c++) begin
         step(1'b1, 1'b1);
         if (c == 0) chk("single_pop", {31'b0, s_rden}, 32'd1);
         else chk("single_nopop", {31'b0, s_rden}, 32'd0);
         if (c >= 1 && c <= 4) begin
            chk("single_valid", {31'b0, s_valid}, 32'd1);
            chk("single_data", s_data, lit_a[c-1]);
            chk("single_last", {31'b0, s_last}, {31'b0, (c == 4)});
         end
         if (c == 5) chk("single_idle", {31'b0, s_valid}, 32'd0);
      end

      // Back-to-back, three words
      for (int i = 0; i < 3; i++) fifo_q.push_back({$urandom, $urandom, $urandom, $urandom});
      pops = 0; beats = 0; runs = 0; prev_v = 1'b0; rden_at_last = 1'b0; first_last_seen = 1'b0;
      for (int c = 0; c < 16; c++) begin
         step(1'b1, 1'b1);
         if (s_rden) pops++;
         if (s_valid) beats++;
         if (s_valid && !prev_v) runs++;
         if (s_last && !first_last_seen) begin
            first_last_seen = 1'b1;
            rden_at_last = s_rden;
         end
         prev_v = s_valid;
      end
      chk("b2b_pops", 32'(pops), 32'd3);
      chk("b2b_beats", 32'(beats), 32'd12);
      chk("b2b_runs", 32'(runs), 32'd1);
      chk("b2b_pop_at_last", {31'b0, rden_at_last}, 32'd1);

      // Backpressure during beat 1
      fifo_q.push_back(word_a);
      fifo_q.push_back(word_b);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      chk("bp_beat0", s_data, lit_a[0]);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1);
         chk("bp_hold_data", s_data, lit_a[1]);
         chk("bp_hold_valid", {31'b0, s_valid}, 32'd1);
         chk("bp_nopop", {31'b0, s_rden}, 32'd0);
      end
      for (int k = 1; k < 4; k++) begin
         step(1'b1, 1'b1);
         chk("bp_resume", s_data, lit_a[k]);
      end
      chk("bp_pop_next", {31'b0, s_rden}, 32'd1);
      drain();

      // Empty FIFO
      for (int i = 0; i < 20; i++) begin
         step(1'($urandom_range(0, 1)), 1'b1);
         chk("empty_rden", {31'b0, s_rden}, 32'd0);
         chk("empty_valid", {31'b0, s_valid}, 32'd0);
      end

      // Reset mid-word
      fifo_q.push_back(word_a);
      fifo_q.push_back(word_b);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      chk("rmid_beat1", s_data, lit_a[1]);
      step(1'b1, 1'b0);
      chk("rmid_valid", {31'b0, s_valid}, 32'd0);
      chk("rmid_data", s_data, 32'd0);
      chk("rmid_last", {31'b0, s_last}, 32'd0);
      chk("rmid_rden", {31'b0, s_rden}, 32'd0);
      step(1'b1, 1'b0);
      seen = 0;
      for (int i = 0; i < 6 && seen == 0; i++) begin
         step(1'b1, 1'b1);
         if (s_valid) begin
            seen = 1;
            chk("rmid_restart", s_data, lit_b0);
         end
      end
      if (seen == 0) chk("rmid_timeout", 32'd0, 32'd1);
      drain();

      // Randomized traffic with occasional resets
      for (int c = 0; c < 3000; c++) begin
         if (fifo_q.size() < 4 && $urandom_range(0, 2) == 0)
            fifo_q.push_back({$urandom, $urandom, $urandom, $urandom});
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 399) != 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
